// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states,
// the captured-request payload and request legality helpers.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_BITS = 3;

  localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  // Request fields that must survive past the acceptance cycle.
  typedef struct packed {
    logic               we;
    logic [F3_BITS-1:0] funct3;
    logic [1:0]         lane;
    logic [15:0]        wdata_lo;
    logic               err;
  } lsu_req_t;

  function automatic logic is_misaligned(input logic [F3_BITS-1:0] funct3,
                                         input logic [1:0]         addr_lo);
    case (funct3)
      F3_H, F3_HU: is_misaligned = addr_lo[0];
      F3_W:        is_misaligned = (addr_lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Unsigned widths only exist for loads; unlisted codes are never legal.
  function automatic logic is_illegal(input logic [F3_BITS-1:0] funct3,
                                      input logic               we);
    case (funct3)
      F3_B, F3_H, F3_W: is_illegal = 1'b0;
      F3_BU, F3_HU:     is_illegal = we;
      default:          is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [F3_BITS-1:0] i_funct3,
  input  logic [1:0]         i_lane,
  input  logic [DATA_W-1:0]  i_rd_word,
  input  logic [DATA_W-1:0]  i_base_word,
  input  logic [15:0]        i_wdata,
  output logic [DATA_W-1:0]  o_load_data_c,
  output logic [DATA_W-1:0]  o_merged_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane select, then sign or zero extension by width code.
  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0: w_byte = i_rd_word[7:0];
      2'd1: w_byte = i_rd_word[15:8];
      2'd2: w_byte = i_rd_word[23:16];
      2'd3: w_byte = i_rd_word[31:24];
    endcase
    w_half = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    o_load_data_c = i_rd_word;
    case (i_funct3)
      F3_B:    o_load_data_c = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data_c = {24'h000000, w_byte};
      F3_H:    o_load_data_c = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data_c = {16'h0000, w_half};
      default: o_load_data_c = i_rd_word;
    endcase
  end

  // Only SB/SH reach the merge; everything outside the addressed lane is kept.
  always_comb begin
    o_merged_c = i_base_word;
    if (i_funct3 == F3_H) begin
      if (i_lane[1]) o_merged_c[31:16] = i_wdata;
      else           o_merged_c[15:0]  = i_wdata;
    end else begin
      case (i_lane)
        2'd0: o_merged_c[7:0]   = i_wdata[7:0];
        2'd1: o_merged_c[15:8]  = i_wdata[7:0];
        2'd2: o_merged_c[23:16] = i_wdata[7:0];
        2'd3: o_merged_c[31:24] = i_wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-wide data memory.
// Handles sub-word loads, read-modify-write stores and request error checks.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [F3_BITS-1:0]  req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  lsu_req_t          r_req;
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_accept;
  logic              w_req_err;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_err_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              w_mem_read_nxt;
  logic              w_mem_write_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic [DATA_W-1:0] w_load_data_c;
  logic [DATA_W-1:0] w_merged_c;

  lsu_byte_lane u_byte_lane (
    .i_funct3      (r_req.funct3),
    .i_lane        (r_req.lane),
    .i_rd_word     (r_word),
    .i_base_word   (mem_rdata),
    .i_wdata       (r_req.wdata_lo),
    .o_load_data_c (w_load_data_c),
    .o_merged_c    (w_merged_c)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    w_next_state    = r_state;
    w_accept        = req_valid && (r_state == IDLE);
    w_req_err       = is_illegal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0]);
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_mem_wdata_nxt = '0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)              w_next_state = RESP;
          else if (!req_we)           w_next_state = LOAD;
          else if (req_funct3 == F3_W) w_next_state = STORE;
          else                        w_next_state = RMW_RD;
        end
      end
      LOAD:    w_next_state = RESP;
      RMW_RD:  w_next_state = STORE;
      STORE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase

    w_mem_read_nxt  = (w_next_state == LOAD) || (w_next_state == RMW_RD);
    w_mem_write_nxt = (w_next_state == STORE);
    if (w_next_state == STORE) begin
      w_mem_wdata_nxt = (r_state == RMW_RD) ? w_merged_c : req_wdata;
    end

    // The response appears the cycle after RESP, so it is formed in RESP.
    if (r_state == RESP) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_err_nxt   = r_req.err;
      if (!r_req.we && !r_req.err) w_rsp_rdata_nxt = w_load_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_word      <= '0;
      r_mem_addr  <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_accept) begin
        r_req.we       <= req_we;
        r_req.funct3   <= req_funct3;
        r_req.lane     <= req_addr[1:0];
        r_req.wdata_lo <= req_wdata[15:0];
        r_req.err      <= w_req_err;
        r_mem_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
      end
      if (r_state == LOAD) r_word <= mem_rdata;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word-wide data memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // data_mem: combinational read, write at the rising edge, not reset.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   write_cnt = 0;
  int   act_cnt = 0;
  int   both_cnt = 0;
  int   leak_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response checker and memory-side activity counters.
  always @(negedge clk) begin
    exp_t e;
    if (mem_read && mem_write) both_cnt++;
    if (mem_read || mem_write) act_cnt++;
    if (mem_write) write_cnt++;
    if (!mem_write && mem_wdata != 32'h0) leak_cnt++;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_cycle", 32'(cyc), 32'(e.due));
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      check_eq("rsp_missing", 32'(rsp_valid), 32'h1);
      void'(exp_q.pop_front());
    end
  end

  // Presents a request (req_valid left high) and waits for acceptance.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic e_err, input logic [31:0] e_rd,
                      input int lat, output int t_acc, output int n_wait);
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n_wait = 0;
    while (!req_ready && n_wait < 16) begin
      @(negedge clk);
      n_wait++;
    end
    if (!req_ready) begin
      check_eq("accept_timeout", 32'(req_ready), 32'h1);
      t_acc = -1;
    end else begin
      t_acc   = cyc + 1;
      e.err   = e_err;
      e.rdata = e_rd;
      e.due   = t_acc + lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic e_err, input logic [31:0] e_rd,
                    input int lat);
    int t;
    int w;
    send(we, f3, addr, wdata, e_err, e_rd, lat, t, w);
    idle_req();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    int a0;
    int t1;
    int t2;
    int nw;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_err",   32'(rsp_err),   32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata,      32'h0);
    check_eq("rst_mem_read",  32'(mem_read),  32'h0);
    check_eq("rst_mem_write", 32'(mem_write), 32'h0);
    check_eq("rst_mem_addr",  mem_addr,       32'h0);
    check_eq("rst_mem_wdata", mem_wdata,      32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'h1);

    // SW then LW at 0x4.
    w0 = write_cnt;
    op(1'b1, F3_W, 32'h4, 32'hA1B2C3D4, 1'b0, 32'h0, 2);
    check_eq("sw_write_cycles", 32'(write_cnt - w0), 32'h1);
    op(1'b0, F3_W, 32'h4, 32'h0, 1'b0, 32'hA1B2C3D4, 2);

    // Sub-word loads from 0xABCDDEAD.
    op(1'b1, F3_W,  32'h0, 32'hABCDDEAD, 1'b0, 32'h0, 2);
    op(1'b0, F3_B,  32'h1, 32'h0, 1'b0, 32'hFFFFFFDE, 2);
    op(1'b0, F3_BU, 32'h1, 32'h0, 1'b0, 32'h000000DE, 2);
    op(1'b0, F3_H,  32'h2, 32'h0, 1'b0, 32'hFFFFABCD, 2);
    op(1'b0, F3_HU, 32'h2, 32'h0, 1'b0, 32'h0000ABCD, 2);
    op(1'b0, F3_B,  32'h3, 32'h0, 1'b0, 32'hFFFFFFAB, 2);
    op(1'b0, F3_BU, 32'h0, 32'h0, 1'b0, 32'h000000AD, 2);
    op(1'b0, F3_H,  32'h0, 32'h0, 1'b0, 32'hFFFFDEAD, 2);

    // Read-modify-write stores; upper wdata bits must not leak into memory.
    op(1'b1, F3_B, 32'h2, 32'hFFFFFF55, 1'b0, 32'h0, 3);
    check_eq("sb_word", mem[0], 32'hAB55DEAD);
    op(1'b1, F3_H, 32'h0, 32'hFFFF1234, 1'b0, 32'h0, 3);
    check_eq("sh_word", mem[0], 32'hAB551234);
    op(1'b0, F3_W, 32'h0, 32'h0, 1'b0, 32'hAB551234, 2);

    // Misaligned and illegal requests: error response, no memory traffic.
    a0 = act_cnt;
    op(1'b0, F3_W,   32'h6, 32'h0,        1'b1, 32'h0, 1);
    op(1'b1, F3_H,   32'h1, 32'h0000BEEF, 1'b1, 32'h0, 1);
    op(1'b0, 3'b011, 32'h0, 32'h0,        1'b1, 32'h0, 1);
    op(1'b1, F3_BU,  32'h0, 32'h000000EE, 1'b1, 32'h0, 1);
    op(1'b0, F3_HU,  32'h3, 32'h0,        1'b1, 32'h0, 1);
    check_eq("err_mem_activity", 32'(act_cnt - a0), 32'h0);
    check_eq("err_word_kept", mem[0], 32'hAB551234);

    // Reset during RMW_RD of SB 0x1: no write, no response.
    w0 = write_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h1; req_wdata = 32'h00000077;
    check_eq("rst_test_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rmw_rd_read", 32'(mem_read), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_ready", 32'(req_ready), 32'h1);
    repeat (5) @(negedge clk);
    check_eq("rst_mid_no_write", 32'(write_cnt - w0), 32'h0);
    check_eq("rst_mid_word", mem[0], 32'hAB551234);
    op(1'b0, F3_W, 32'h0, 32'h0, 1'b0, 32'hAB551234, 2);

    // Back-to-back loads with req_valid held high.
    send(1'b0, F3_W, 32'h4, 32'h0, 1'b0, 32'hA1B2C3D4, 2, t1, nw);
    send(1'b0, F3_B, 32'h2, 32'h0, 1'b0, 32'h00000055, 2, t2, nw);
    check_eq("b2b_busy_cycles", 32'(nw), 32'h2);
    check_eq("b2b_accept_edge", 32'(t2), 32'(t1 + 3));
    idle_req();
    drain();

    check_eq("rd_wr_overlap", 32'(both_cnt), 32'h0);
    check_eq("wdata_outside_store", 32'(leak_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
